board_sequencer: RTL
====================

BOARD_SEQUENCER -- requirements
Module: board_sequencer

Interface
REQ-001 Parameter LEFT_EDGE, default 24: hcount-space x threshold at or below which P2 exits the screen leftward.
REQ-002 Parameter RIGHT_EDGE, default 1000: x threshold at or above which P1 exits the screen rightward.
REQ-003 Parameter FADE_FRAMES, default 16: frames per fade half (out or in); legal range 2..16.
REQ-004 clk  in  1  pixel clock shared with the board renderer.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 vsync_in  in  1  timing-chain vsync; its rising edge defines one frame tick.
REQ-007 start  in  1  one-cycle pulse; starts a game or clears a finished one.
REQ-008 p1_kill / p2_kill  in  1 each  one-cycle pulse; P1 killed P2 / P2 killed P1.
REQ-009 p1_xpos / p2_xpos  in  12 each  player x positions, unsigned.
REQ-010 board_offset  out  3  two's-complement board index offset, range -2..+2, for the board renderer's board_controller input.
REQ-011 fade_level  out  4  darkening level: 0 = none, FADE_FRAMES-1 = full black.
REQ-012 busy  out  1  high while a board transition is in progress.
REQ-013 respawn  out  1  one-cycle pulse on each board change.
REQ-014 lead  out  2  right of way: 00 none, 01 P1, 10 P2.
REQ-015 winner  out  2  00 none, 01 P1, 10 P2.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 Frame tick: vsync_in SHALL be registered once; tick = vsync_in & ~vsync_q, one cycle wide.
REQ-018 The FSM SHALL have the states IDLE, PLAY, FADE_OUT, FADE_IN and WIN.
REQ-019 IDLE: board_offset = 0, lead = 00, winner = 00; start -> PLAY on the next cycle.
REQ-020 PLAY, p1_kill alone: lead <= 01 on the next cycle.
REQ-021 PLAY, p2_kill alone: lead <= 10.
REQ-022 PLAY, p1_kill and p2_kill in the same cycle: lead <= 00.
REQ-023 PLAY, on a tick with lead = 01 and p1_xpos >= RIGHT_EDGE: if board_offset = +2, go to WIN with winner <= 01; otherwise go to FADE_OUT with dir = +1.
REQ-024 PLAY, on a tick with lead = 10 and p2_xpos <= LEFT_EDGE: if board_offset = -2, go to WIN with winner <= 10; otherwise go to FADE_OUT with dir = -1.
REQ-025 Edge checks SHALL be evaluated only on tick cycles; when a kill pulse coincides with a tick, the edge check SHALL use the pre-update lead value.
REQ-026 FADE_OUT: fade_level SHALL increment by 1 per tick, starting from 0.
REQ-027 On the tick where fade_level = FADE_FRAMES-1 in FADE_OUT: board_offset <= board_offset + dir (3-bit wrap arithmetic), respawn high for exactly that one cycle, go to FADE_IN.
REQ-028 FADE_IN: fade_level SHALL decrement by 1 per tick; on the tick where it reaches 0, go to PLAY.
REQ-029 busy SHALL be 1 in FADE_OUT and FADE_IN, and 0 in all other states.
REQ-030 Transition latency SHALL be 2*FADE_FRAMES-1 ticks from entering FADE_OUT to returning to PLAY.
REQ-031 Kill pulses and start SHALL be ignored in FADE_OUT and FADE_IN.
REQ-032 lead SHALL be preserved across a transition.
REQ-033 WIN: board_offset, winner and lead SHALL hold; fade_level = 0; start -> IDLE, clearing offset, lead and winner.
REQ-034 board_offset SHALL never leave -2..+2 (encodings 110, 111, 000, 001, 010).
REQ-035 start in PLAY SHALL restart the game: board_offset <= 0, lead <= 00, state stays PLAY.

Reset
REQ-036 reset low SHALL asynchronously force IDLE, board_offset = 0, fade_level = 0, busy = 0, respawn = 0, lead = 00, winner = 00, vsync_q = 0.
REQ-037 Reset asserted mid-transition SHALL abort the transition with no respawn pulse.
REQ-038 Release SHALL be synchronous to clk; the first tick SHALL occur no earlier than the first vsync_in rising edge seen after release.

Verification
REQ-039 start, p1_kill, p1_xpos = 1000, one tick -> busy = 1; after 16 ticks, board_offset = 001 with one respawn pulse; after 15 more ticks, busy = 0 and the FSM is in PLAY.
REQ-040 Repeat the P1 run from offset +2 with p1_xpos = 1020 -> winner = 01, board_offset stays 010, busy stays 0; start -> all outputs return to 0.
REQ-041 p2_kill, p2_xpos = 24, two transitions -> board_offset = 110; a third exit -> winner = 10.
REQ-042 p1_kill and p2_kill in the same cycle -> lead = 00; p1_xpos = 1023 on ticks -> no transition.
REQ-043 p2_kill during FADE_OUT -> lead unchanged; reset low at fade_level = 7 -> every output is 0 immediately and no respawn pulse occurs.
REQ-044 p1_xpos = 999 with lead = 01 -> no transition; vsync_in held high across many cycles -> only one tick is counted.

Source files
------------

// File: rtl/board_sequencer_if.sv
// Groups the board sequencer's frame-timing, player-event and board-status
// signals into one bundle shared by the sequencer and its driver.
interface board_sequencer_if;
  logic        vsync_in;
  logic        start;
  logic        p1_kill;
  logic        p2_kill;
  logic [11:0] p1_xpos;
  logic [11:0] p2_xpos;
  logic [2:0]  board_offset;
  logic [3:0]  fade_level;
  logic        busy;
  logic        respawn;
  logic [1:0]  lead;
  logic [1:0]  winner;

  modport master (
    output vsync_in, start, p1_kill, p2_kill, p1_xpos, p2_xpos,
    input  board_offset, fade_level, busy, respawn, lead, winner
  );

  modport slave (
    input  vsync_in, start, p1_kill, p2_kill, p1_xpos, p2_xpos,
    output board_offset, fade_level, busy, respawn, lead, winner
  );
endinterface

// File: rtl/board_sequencer.sv
// Tracks right of way, screen exits and board changes for a two-player
// duel, fading out/in across each board change and declaring a winner.
module board_sequencer #(
  parameter int unsigned LEFT_EDGE   = 24,
  parameter int unsigned RIGHT_EDGE  = 1000,
  parameter int unsigned FADE_FRAMES = 16
) (
  input  logic               clk,
  input  logic               reset,
  board_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_FADE_OUT,
    S_FADE_IN,
    S_WIN
  } state_t;

  localparam logic [11:0] LEFT_X   = 12'(LEFT_EDGE);
  localparam logic [11:0] RIGHT_X  = 12'(RIGHT_EDGE);
  localparam logic [3:0]  FADE_MAX = 4'(FADE_FRAMES - 1);
  localparam logic [1:0]  LEAD_P1  = 2'b01;
  localparam logic [1:0]  LEAD_P2  = 2'b10;
  localparam logic [2:0]  OFF_POS2 = 3'b010;
  localparam logic [2:0]  OFF_NEG2 = 3'b110;

  state_t      state_q, state_d;
  logic [2:0]  offset_q, offset_d;
  logic [3:0]  fade_q, fade_d;
  logic [1:0]  lead_q, lead_d;
  logic [1:0]  winner_q, winner_d;
  logic        dir_q, dir_d;
  logic        respawn_q, respawn_d;
  logic        busy_q, busy_d;
  logic        vsync_q;
  logic        armed_q;
  logic        tick;

  // armed_q blocks a false tick when vsync is already high as reset releases.
  assign tick = bus.vsync_in & ~vsync_q & armed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      offset_q  <= '0;
      fade_q    <= '0;
      lead_q    <= '0;
      winner_q  <= '0;
      dir_q     <= 1'b0;
      respawn_q <= 1'b0;
      busy_q    <= 1'b0;
      vsync_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      fade_q    <= fade_d;
      lead_q    <= lead_d;
      winner_q  <= winner_d;
      dir_q     <= dir_d;
      respawn_q <= respawn_d;
      busy_q    <= busy_d;
      vsync_q   <= bus.vsync_in;
      armed_q   <= armed_q | ~bus.vsync_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    fade_d    = fade_q;
    lead_d    = lead_q;
    winner_d  = winner_q;
    dir_d     = dir_q;
    respawn_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        offset_d = '0;
        fade_d   = '0;
        lead_d   = '0;
        winner_d = '0;
        if (bus.start) state_d = S_PLAY;
      end

      S_PLAY: begin
        fade_d = '0;
        if (bus.start) begin
          offset_d = '0;
          lead_d   = '0;
        end else begin
          if (bus.p1_kill && bus.p2_kill)  lead_d = '0;
          else if (bus.p1_kill)            lead_d = LEAD_P1;
          else if (bus.p2_kill)            lead_d = LEAD_P2;

          // Exit tests use lead_q, so a same-cycle kill cannot trigger an exit.
          if (tick) begin
            if (lead_q == LEAD_P1 && bus.p1_xpos >= RIGHT_X) begin
              if (offset_q == OFF_POS2) begin
                state_d  = S_WIN;
                winner_d = LEAD_P1;
              end else begin
                state_d = S_FADE_OUT;
                dir_d   = 1'b0;
              end
            end else if (lead_q == LEAD_P2 && bus.p2_xpos <= LEFT_X) begin
              if (offset_q == OFF_NEG2) begin
                state_d  = S_WIN;
                winner_d = LEAD_P2;
              end else begin
                state_d = S_FADE_OUT;
                dir_d   = 1'b1;
              end
            end
          end
        end
      end

      S_FADE_OUT: begin
        if (tick) begin
          if (fade_q == FADE_MAX) begin
            offset_d  = offset_q + (dir_q ? 3'b111 : 3'b001);
            respawn_d = 1'b1;
            state_d   = S_FADE_IN;
          end else begin
            fade_d = fade_q + 4'd1;
          end
        end
      end

      S_FADE_IN: begin
        if (tick) begin
          fade_d = fade_q - 4'd1;
          if (fade_q == 4'd1) state_d = S_PLAY;
        end
      end

      S_WIN: begin
        fade_d = '0;
        if (bus.start) begin
          state_d  = S_IDLE;
          offset_d = '0;
          lead_d   = '0;
          winner_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FADE_OUT) || (state_d == S_FADE_IN);
  end

  assign bus.board_offset = offset_q;
  assign bus.fade_level   = fade_q;
  assign bus.busy         = busy_q;
  assign bus.respawn      = respawn_q;
  assign bus.lead         = lead_q;
  assign bus.winner       = winner_q;

endmodule
